// File: rtl/serial_port_init_sequencer.sv
// Purpose: writes baud divisor, line format, FIFO and IER setup into the BT/WiFi/USB 16550 ports, then hands the IO bus to the CPU.
// Latency: Init_Done_H rises POWERUP_CYCLES + 18*(1+WRITE_CYCLES+GAP_CYCLES) clocks after reset release (142 with defaults).
// Backpressure: CPU IO accesses are stalled via CPU_WaitRequest_H while sequencing; a restart waits for any in-flight CPU access to end.
module serial_port_init_sequencer #(
  parameter logic [15:0] DIVISOR_BT     = 16'd27,
  parameter logic [15:0] DIVISOR_WIFI   = 16'd27,
  parameter logic [15:0] DIVISOR_USB    = 16'd27,
  parameter int          POWERUP_CYCLES = 16,
  parameter int          WRITE_CYCLES   = 4,
  parameter int          GAP_CYCLES     = 2
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        Start_H,
  input  logic [15:0] CPU_Address,
  input  logic        CPU_IOSelect_H,
  input  logic        CPU_ByteSelect_L,
  input  logic        CPU_WE_L,
  input  logic [7:0]  CPU_DataOut,
  output logic [15:0] Address,
  output logic        IOSelect_H,
  output logic        ByteSelect_L,
  output logic        WE_L,
  output logic [7:0]  DataOut,
  output logic        CPU_WaitRequest_H,
  output logic        Init_Done_H,
  output logic        Busy_H
);

  typedef enum logic [2:0] {
    S_POWERUP, S_SETUP, S_STROBE, S_GAP, S_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        io_sel;
    logic        byte_sel_l;
    logic        we_l;
    logic [7:0]  data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{addr: 16'h0000, io_sel: 1'b0, byte_sel_l: 1'b1,
                                we_l: 1'b1, data: 8'h00};

  localparam logic [15:0] PU_LAST  = 16'(POWERUP_CYCLES - 1);
  localparam logic [15:0] WR_LAST  = 16'(WRITE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  port_idx, port_nxt;
  logic [2:0]  reg_idx, reg_nxt;
  logic        pending, pending_nxt;
  bus_t        bus_q, bus_nxt;
  logic        in_done;

  function automatic logic [15:0] divisor_of(input logic [1:0] p);
    case (p)
      2'd0:    return DIVISOR_BT;
      2'd1:    return DIVISOR_WIFI;
      default: return DIVISOR_USB;
    endcase
  endfunction

  // Register map per step: LCR.DLAB=1, DLL, DLM, LCR=8N1, FCR enable+clear, IER=0
  function automatic logic [15:0] addr_of(input logic [1:0] p, input logic [2:0] r);
    logic [3:0] off;
    case (r)
      3'd0:    off = 4'd6;
      3'd1:    off = 4'd0;
      3'd2:    off = 4'd2;
      3'd3:    off = 4'd6;
      3'd4:    off = 4'd4;
      default: off = 4'd2;
    endcase
    return 16'h0200 + {10'd0, p, 4'd0} + {12'd0, off};
  endfunction

  function automatic logic [7:0] data_of(input logic [1:0] p, input logic [2:0] r);
    logic [15:0] div;
    div = divisor_of(p);
    case (r)
      3'd0:    return 8'h80;
      3'd1:    return div[7:0];
      3'd2:    return div[15:8];
      3'd3:    return 8'h03;
      3'd4:    return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  // State, step indices, restart request and registered bus drive
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state    <= S_POWERUP;
      cnt      <= '0;
      port_idx <= '0;
      reg_idx  <= '0;
      pending  <= 1'b0;
      bus_q    <= BUS_IDLE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      port_idx <= port_nxt;
      reg_idx  <= reg_nxt;
      pending  <= pending_nxt;
      bus_q    <= bus_nxt;
    end
  end

  // Next-state sequencing; bus drive is computed from the next state so it lines up with it
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    port_nxt    = port_idx;
    reg_nxt     = reg_idx;
    pending_nxt = pending;
    bus_nxt     = BUS_IDLE;

    case (state)
      S_POWERUP: begin
        if (cnt == PU_LAST) begin
          state_nxt = S_SETUP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_SETUP: begin
        state_nxt = S_STROBE;
        cnt_nxt   = '0;
      end
      S_STROBE: begin
        if (cnt == WR_LAST) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (port_idx == 2'd2 && reg_idx == 3'd5) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SETUP;
            if (reg_idx == 3'd5) begin
              reg_nxt  = '0;
              port_nxt = port_idx + 2'd1;
            end else begin
              reg_nxt = reg_idx + 3'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_DONE: begin
        // Never cut a CPU access in progress: hold the restart until IOSelect drops
        if (Start_H || pending) begin
          if (!CPU_IOSelect_H) begin
            state_nxt   = S_POWERUP;
            cnt_nxt     = '0;
            port_nxt    = '0;
            reg_nxt     = '0;
            pending_nxt = 1'b0;
          end else begin
            pending_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_POWERUP;
    endcase

    case (state_nxt)
      S_SETUP, S_STROBE: begin
        bus_nxt.addr       = addr_of(port_nxt, reg_nxt);
        bus_nxt.data       = data_of(port_nxt, reg_nxt);
        bus_nxt.io_sel     = 1'b1;
        bus_nxt.byte_sel_l = 1'b0;
        bus_nxt.we_l       = (state_nxt != S_STROBE);
      end
      S_GAP: begin
        bus_nxt.addr = addr_of(port_nxt, reg_nxt);
        bus_nxt.data = data_of(port_nxt, reg_nxt);
      end
      default: bus_nxt = BUS_IDLE;
    endcase
  end

  assign in_done = (state == S_DONE);

  // Bus ownership mux: CPU passes straight through only once sequencing is complete
  assign Address           = in_done ? CPU_Address      : bus_q.addr;
  assign IOSelect_H        = in_done ? CPU_IOSelect_H   : bus_q.io_sel;
  assign ByteSelect_L      = in_done ? CPU_ByteSelect_L : bus_q.byte_sel_l;
  assign WE_L              = in_done ? CPU_WE_L         : bus_q.we_l;
  assign DataOut           = in_done ? CPU_DataOut      : bus_q.data;
  assign CPU_WaitRequest_H = in_done ? 1'b0             : CPU_IOSelect_H;
  assign Init_Done_H       = in_done;
  assign Busy_H            = ~in_done;

endmodule

// File: tb/tb_serial_port_init_sequencer.sv
// Purpose: directed bench for serial_port_init_sequencer with a write-logging bus monitor.
// Latency: each phase is a fixed cycle count from reset release or restart.
// Backpressure: CPU IO select is held across the sequence to exercise the stall.
module tb_serial_port_init_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_H = 1'b1;
  logic        Start_H = 1'b0;
  logic [15:0] CPU_Address = 16'h0000;
  logic        CPU_IOSelect_H = 1'b0;
  logic        CPU_ByteSelect_L = 1'b1;
  logic        CPU_WE_L = 1'b1;
  logic [7:0]  CPU_DataOut = 8'h00;
  logic [15:0] Address;
  logic        IOSelect_H, ByteSelect_L, WE_L;
  logic [7:0]  DataOut;
  logic        CPU_WaitRequest_H, Init_Done_H, Busy_H;

  int checks = 0;
  int failures = 0;
  int leaks = 0;
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        prev_we = 1'b1;

  serial_port_init_sequencer #(.DIVISOR_WIFI(16'h1234)) dut (
    .Clock(Clock), .Reset_H(Reset_H), .Start_H(Start_H),
    .CPU_Address(CPU_Address), .CPU_IOSelect_H(CPU_IOSelect_H),
    .CPU_ByteSelect_L(CPU_ByteSelect_L), .CPU_WE_L(CPU_WE_L),
    .CPU_DataOut(CPU_DataOut),
    .Address(Address), .IOSelect_H(IOSelect_H), .ByteSelect_L(ByteSelect_L),
    .WE_L(WE_L), .DataOut(DataOut), .CPU_WaitRequest_H(CPU_WaitRequest_H),
    .Init_Done_H(Init_Done_H), .Busy_H(Busy_H)
  );

  always #5 Clock = ~Clock;

  // Log each sequencer-driven write (WE_L falling while busy) and any CPU data leaking onto the bus
  always @(negedge Clock) begin
    if (Busy_H && IOSelect_H && !WE_L && prev_we) begin
      log_addr.push_back(Address);
      log_data.push_back(DataOut);
    end
    if (Busy_H && (Address == 16'h0300 || DataOut == 8'hAA)) leaks = leaks + 1;
    prev_we = WE_L;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] exp_addr(input int i);
    int offs [6] = '{6, 0, 2, 6, 4, 2};
    return 16'h0200 + 16'((i / 6) * 16) + 16'(offs[i % 6]);
  endfunction

  function automatic logic [7:0] exp_data(input int i);
    logic [15:0] d;
    d = ((i / 6) == 1) ? 16'h1234 : 16'd27;
    case (i % 6)
      0: return 8'h80;
      1: return d[7:0];
      2: return d[15:8];
      3: return 8'h03;
      4: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_log(input string run);
    chk({run, "_write_count"}, log_addr.size(), 18);
    for (int i = 0; i < 18 && i < log_addr.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", run, i), log_addr[i], exp_addr(i));
      chk($sformatf("%s_wr%0d_data", run, i), log_data[i], exp_data(i));
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    // ---- Run A: reset release with defaults ----
    ticks(3);
    Reset_H = 1'b0;
    clear_log();
    // cycle 0
    chk("rst_addr", Address, 16'h0000);
    chk("rst_iosel", IOSelect_H, 1'b0);
    chk("rst_bsel", ByteSelect_L, 1'b1);
    chk("rst_we", WE_L, 1'b1);
    chk("rst_data", DataOut, 8'h00);
    chk("rst_busy", Busy_H, 1'b1);
    chk("rst_done", Init_Done_H, 1'b0);
    ticks(15);
    chk("c15_iosel", IOSelect_H, 1'b0);
    tick(); // cycle 16: first SETUP
    chk("c16_addr", Address, 16'h0206);
    chk("c16_data", DataOut, 8'h80);
    chk("c16_iosel", IOSelect_H, 1'b1);
    chk("c16_bsel", ByteSelect_L, 1'b0);
    chk("c16_we", WE_L, 1'b1);
    tick(); // 17
    chk("c17_we", WE_L, 1'b0);
    ticks(3); // 20
    chk("c20_we", WE_L, 1'b0);
    tick(); // 21: GAP
    chk("c21_we", WE_L, 1'b1);
    chk("c21_iosel", IOSelect_H, 1'b0);
    chk("c21_bsel", ByteSelect_L, 1'b1);
    chk("c21_addr_hold", Address, 16'h0206);
    ticks(29); // 50: CPU starts an access
    CPU_Address = 16'h0300; CPU_DataOut = 8'hAA;
    CPU_IOSelect_H = 1'b1; CPU_ByteSelect_L = 1'b0; CPU_WE_L = 1'b0;
    #1;
    chk("c50_wait", CPU_WaitRequest_H, 1'b1);
    ticks(10); // 60: start pulse mid-sequence is ignored
    Start_H = 1'b1;
    tick();
    Start_H = 1'b0;
    ticks(80); // 141
    chk("c141_done", Init_Done_H, 1'b0);
    chk("c141_wait", CPU_WaitRequest_H, 1'b1);
    tick(); // 142
    chk("c142_done", Init_Done_H, 1'b1);
    chk("c142_busy", Busy_H, 1'b0);
    chk("c142_wait", CPU_WaitRequest_H, 1'b0);
    chk("cpu_leaks", leaks, 0);
    check_log("runA");
    CPU_Address = 16'h0220; CPU_DataOut = 8'h55;
    #1;
    chk("pass_addr", Address, 16'h0220);
    chk("pass_we", WE_L, 1'b0);
    chk("pass_data", DataOut, 8'h55);
    chk("pass_iosel", IOSelect_H, 1'b1);

    // ---- Run B: Start_H in DONE while CPU access is in flight ----
    Start_H = 1'b1;
    tick();
    Start_H = 1'b0;
    chk("pend1_done", Init_Done_H, 1'b1);
    tick();
    chk("pend2_done", Init_Done_H, 1'b1);
    tick();
    chk("pend3_done", Init_Done_H, 1'b1);
    CPU_IOSelect_H = 1'b0; CPU_WE_L = 1'b1; CPU_ByteSelect_L = 1'b1;
    tick(); // restart: cycle 0 of new sequence
    clear_log();
    chk("restart_done", Init_Done_H, 1'b0);
    chk("restart_busy", Busy_H, 1'b1);
    chk("restart_addr", Address, 16'h0000);
    ticks(16);
    chk("rB_c16_addr", Address, 16'h0206);
    ticks(125);
    chk("rB_c141_done", Init_Done_H, 1'b0);
    tick();
    chk("rB_c142_done", Init_Done_H, 1'b1);
    check_log("runB");

    // ---- Run C: reset mid-STROBE, coincident with Start_H ----
    Reset_H = 1'b1;
    tick();
    Reset_H = 1'b0;
    ticks(68); // cycle 68: STROBE of write 7 (WiFi DLL)
    chk("c68_we", WE_L, 1'b0);
    chk("c68_addr", Address, 16'h0210);
    chk("c68_data", DataOut, 8'h34);
    Reset_H = 1'b1; Start_H = 1'b1;
    tick();
    chk("midrst_we", WE_L, 1'b1);
    chk("midrst_iosel", IOSelect_H, 1'b0);
    chk("midrst_addr", Address, 16'h0000);
    chk("midrst_busy", Busy_H, 1'b1);
    Reset_H = 1'b0; Start_H = 1'b0;
    clear_log();
    ticks(16);
    chk("rC_c16_addr", Address, 16'h0206);
    ticks(125);
    chk("rC_c141_done", Init_Done_H, 1'b0);
    tick();
    chk("rC_c142_done", Init_Done_H, 1'b1);
    check_log("runC");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
